instr_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 28 ++
 rtl/ifu_next_pc.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU: instruction layout, opcodes and the
// fetch-stage state encoding.
package cpu_pkg;

   localparam int INSTR_W   = 24;
   localparam int OPCODE_HI = 23;
   localparam int OPCODE_LO = 20;
   localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0100;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetchState_t;

   function automatic logic [OPCODE_W-1:0] opcodeOf(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_HI:OPCODE_LO];
   endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC selection for the fetch stage: jump, taken branch, or sequential.
// All arithmetic wraps modulo 2^ADDR_W.
module ifu_next_pc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              jump,
   input  logic              branch,
   input  logic              zero,
   input  logic [15:0]       branchOff,
   input  logic [19:0]       jumpTarget,
   output logic [ADDR_W-1:0] nextPc
);

   logic [ADDR_W-1:0] pcPlus1;
   logic [ADDR_W-1:0] branchPc;
   logic [ADDR_W-1:0] jumpPc;

   assign pcPlus1  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign branchPc = pcPlus1 + {{(ADDR_W-16){branchOff[15]}}, branchOff};

   // Jump keeps the upper region of the sequential PC and replaces the low 20 bits.
   if (ADDR_W > 20) begin : gJumpWide
      assign jumpPc = {pcPlus1[ADDR_W-1:20], jumpTarget};
   end else begin : gJumpNarrow
      assign jumpPc = jumpTarget;
   end

   always_comb begin
      nextPc = pcPlus1;
      if (jump) begin
         nextPc = jumpPc;
      end else if (branch && zero) begin
         nextPc = branchPc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage with req/ack memory handshake.
// Optional fetch watchdog enabled by defining IFU_FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | request outstanding at IMemAddr = PC, waiting for ack
// HOLD  | instruction latched and valid; held while Stall is high
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT_CYC = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   output logic [ADDR_W-1:0]   IMemAddr,
   output logic                IMemReq,
   input  logic                IMemAck,
   input  logic [INSTR_W-1:0]  IMemData,
   input  logic                Stall,
   input  logic                Jump,
   input  logic                Branch,
   input  logic                Zero,
   input  logic [15:0]         BranchOff,
   input  logic [19:0]         JumpTarget,
   output logic [INSTR_W-1:0]  Instr,
   output logic [OPCODE_W-1:0] OPCODE,
   output logic                InstrValid,
   output logic [ADDR_W-1:0]   PC,
   output logic                FetchErr
);

   if (ADDR_W < 20 || TIMEOUT_CYC < 1) begin : gParamCheck
      $error("instr_fetch_unit: ADDR_W must be >= 20 and TIMEOUT_CYC >= 1");
   end

   fetchState_t        state, nextState;
   logic [ADDR_W-1:0]  pcReg, nextPc;
   logic [INSTR_W-1:0] instrReg;
   logic               instrValidReg;
   logic               imemReqReg;
   logic               ackTake, timeoutHit, advance, timeoutNow;

   ifu_next_pc #(.ADDR_W(ADDR_W)) uNextPc (
      .pc         (pcReg),
      .jump       (Jump),
      .branch     (Branch),
      .zero       (Zero),
      .branchOff  (BranchOff),
      .jumpTarget (JumpTarget),
      .nextPc     (nextPc)
   );

   always_comb begin
      nextState  = state;
      ackTake    = 1'b0;
      timeoutHit = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: nextState = FETCH;
         FETCH: begin
            if (IMemAck) begin
               ackTake   = 1'b1;
               nextState = HOLD;
            end else if (timeoutNow) begin
               timeoutHit = 1'b1;
               nextState  = HOLD;
            end
         end
         HOLD: begin
            if (!Stall) begin
               advance   = 1'b1;
               nextState = FETCH;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         pcReg         <= RESET_PC;
         instrReg      <= '0;
         instrValidReg <= 1'b0;
         imemReqReg    <= 1'b0;
      end else begin
         state      <= nextState;
         imemReqReg <= (nextState == FETCH);
         if (ackTake) begin
            instrReg      <= IMemData;
            instrValidReg <= 1'b1;
         end else if (timeoutHit) begin
            instrReg      <= NOP_INSTR;
            instrValidReg <= 1'b1;
         end
         if (advance) begin
            pcReg         <= nextPc;
            instrValidReg <= 1'b0;
         end
      end
   end

`ifdef IFU_FETCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wdCnt;
   logic            fetchErrReg;

   // Down-counter reloads outside FETCH, so each fetch gets a fresh budget.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wdCnt       <= WD_LOAD;
         fetchErrReg <= 1'b0;
      end else begin
         if (state != FETCH) begin
            wdCnt <= WD_LOAD;
         end else if (wdCnt != '0) begin
            wdCnt <= wdCnt - 1'b1;
         end
         if (timeoutHit) begin
            fetchErrReg <= 1'b1;
         end
      end
   end

   assign timeoutNow = (wdCnt == '0);
   assign FetchErr   = fetchErrReg;
`else
   assign timeoutNow = 1'b0;
   assign FetchErr   = 1'b0;
`endif

   assign IMemAddr   = pcReg;
   assign IMemReq    = imemReqReg;
   assign PC         = pcReg;
   assign Instr      = instrReg;
   assign OPCODE     = opcodeOf(instrReg);
   assign InstrValid = instrValidReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, branches, jumps,
// wraparound, stalls, delayed acks, mid-fetch reset and the fetch watchdog.
module tb_instr_fetch_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [23:0] IMemAddr;
   logic        IMemReq;
   logic        IMemAck;
   logic [23:0] IMemData;
   logic        Stall;
   logic        Jump;
   logic        Branch;
   logic        Zero;
   logic [15:0] BranchOff;
   logic [19:0] JumpTarget;
   logic [23:0] Instr;
   logic [3:0]  OPCODE;
   logic        InstrValid;
   logic [23:0] PC;
   logic        FetchErr;

   int nChecks = 0;
   int nErrors = 0;

   always #5 Clock = ~Clock;

   instr_fetch_unit #(
      .ADDR_W      (24),
      .RESET_PC    (24'h000100),
      .TIMEOUT_CYC (16)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .IMemAddr   (IMemAddr),
      .IMemReq    (IMemReq),
      .IMemAck    (IMemAck),
      .IMemData   (IMemData),
      .Stall      (Stall),
      .Jump       (Jump),
      .Branch     (Branch),
      .Zero       (Zero),
      .BranchOff  (BranchOff),
      .JumpTarget (JumpTarget),
      .Instr      (Instr),
      .OPCODE     (OPCODE),
      .InstrValid (InstrValid),
      .PC         (PC),
      .FetchErr   (FetchErr)
   );

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One instruction: wait for the request, ack after ackDelay cycles, hold
   // stallCyc cycles (with decoy jump/ack inputs), then release with j/b/z.
   task automatic fetchOne(input logic [23:0] expAddr, input logic [23:0] data,
                           input int ackDelay, input int stallCyc,
                           input logic j, input logic b, input logic z,
                           input logic [15:0] off, input logic [19:0] tgt,
                           input logic [23:0] expNext);
      int waited = 0;
      while (!IMemReq && waited < 20) begin
         @(negedge Clock);
         waited++;
      end
      checkEq("reqSeen", 32'(IMemReq), 32'd1);
      checkEq("fetchAddr", 32'(IMemAddr), 32'(expAddr));
      for (int i = 0; i < ackDelay; i++) begin
         @(posedge Clock); #1;
         checkEq("addrStable", 32'(IMemAddr), 32'(expAddr));
         checkEq("reqHeld", 32'(IMemReq), 32'd1);
         checkEq("notValidYet", 32'(InstrValid), 32'd0);
      end
      IMemAck  = 1'b1;
      IMemData = data;
      @(posedge Clock); #1;
      IMemAck  = 1'b0;
      IMemData = 24'h0F0F0F;
      checkEq("validAfterAck", 32'(InstrValid), 32'd1);
      checkEq("instrLatched", 32'(Instr), 32'(data));
      checkEq("opcode", 32'(OPCODE), 32'(data[23:20]));
      checkEq("pcOfInstr", 32'(PC), 32'(expAddr));
      checkEq("reqDropOnAck", 32'(IMemReq), 32'd0);
      for (int i = 0; i < stallCyc; i++) begin
         Stall      = 1'b1;
         Jump       = 1'b1;
         JumpTarget = 20'h55555;
         IMemAck    = 1'b1;
         IMemData   = 24'hBADBAD;
         @(posedge Clock); #1;
         checkEq("stallInstr", 32'(Instr), 32'(data));
         checkEq("stallPc", 32'(PC), 32'(expAddr));
         checkEq("stallValid", 32'(InstrValid), 32'd1);
         checkEq("stallNoReq", 32'(IMemReq), 32'd0);
      end
      IMemAck    = 1'b0;
      Stall      = 1'b0;
      Jump       = j;
      Branch     = b;
      Zero       = z;
      BranchOff  = off;
      JumpTarget = tgt;
      @(posedge Clock); #1;
      checkEq("validDrop", 32'(InstrValid), 32'd0);
      checkEq("reqNext", 32'(IMemReq), 32'd1);
      checkEq("nextAddr", 32'(IMemAddr), 32'(expNext));
      Jump       = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;
      BranchOff  = '0;
      JumpTarget = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL globalTimeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      Reset = 1'b1; IMemAck = 1'b0; IMemData = '0; Stall = 1'b0;
      Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; BranchOff = '0; JumpTarget = '0;
      repeat (2) @(negedge Clock);
      checkEq("rstReq", 32'(IMemReq), 32'd0);
      checkEq("rstPc", 32'(PC), 32'h100);
      checkEq("rstAddr", 32'(IMemAddr), 32'h100);
      checkEq("rstValid", 32'(InstrValid), 32'd0);
      checkEq("rstInstr", 32'(Instr), 32'd0);
      checkEq("rstOpcode", 32'(OPCODE), 32'd0);
      checkEq("rstErr", 32'(FetchErr), 32'd0);

      Reset = 1'b0;
      #1;
      checkEq("reqCycle1", 32'(IMemReq), 32'd0);
      @(posedge Clock); #1;
      checkEq("reqCycle2", 32'(IMemReq), 32'd1);

      fetchOne(24'h000100, 24'h612345, 0, 0, 0, 0, 0, 16'h0000, 20'h00000, 24'h000101);
      fetchOne(24'h000101, 24'h1ABCDE, 5, 3, 0, 0, 0, 16'h0000, 20'h00000, 24'h000102);
      fetchOne(24'h000102, 24'h200000, 0, 0, 1, 0, 0, 16'h0000, 20'h00010, 24'h000010);
      fetchOne(24'h000010, 24'h4FFFFC, 0, 0, 0, 1, 0, 16'hFFFC, 20'h00000, 24'h000011);
      fetchOne(24'h000011, 24'h500010, 0, 0, 1, 0, 0, 16'h0000, 20'h00010, 24'h000010);
      fetchOne(24'h000010, 24'h4FFFFC, 0, 1, 0, 1, 1, 16'hFFFC, 20'h00000, 24'h00000D);
      fetchOne(24'h00000D, 24'h40FFE0, 0, 0, 0, 1, 1, 16'hFFE0, 20'h00000, 24'hFFFFEE);
      fetchOne(24'hFFFFEE, 24'h5FFFFF, 0, 0, 1, 0, 0, 16'h0000, 20'hFFFFF, 24'hFFFFFF);
      fetchOne(24'hFFFFFF, 24'h600000, 0, 0, 0, 0, 0, 16'h0000, 20'h00000, 24'h000000);
      fetchOne(24'h000000, 24'h5FFFF0, 0, 0, 1, 0, 0, 16'h0000, 20'hFFFF0, 24'h0FFFF0);
      fetchOne(24'h0FFFF0, 24'h400020, 0, 0, 0, 1, 1, 16'h0020, 20'h00000, 24'h100011);
      fetchOne(24'h100011, 24'h5FFFF0, 0, 0, 1, 0, 0, 16'h0000, 20'hFFFF0, 24'h1FFFF0);
      fetchOne(24'h1FFFF0, 24'h400020, 0, 0, 0, 1, 1, 16'h0020, 20'h00000, 24'h200011);
      fetchOne(24'h200011, 24'h5FFFF0, 0, 0, 1, 0, 0, 16'h0000, 20'hFFFF0, 24'h2FFFF0);
      fetchOne(24'h2FFFF0, 24'h400020, 0, 0, 0, 1, 1, 16'h0020, 20'h00000, 24'h300011);
      fetchOne(24'h300011, 24'h5ABCDE, 0, 0, 1, 0, 0, 16'h0000, 20'hABCDE, 24'h3ABCDE);
      fetchOne(24'h3ABCDE, 24'h500040, 2, 0, 1, 1, 1, 16'h0005, 20'h00040, 24'h300040);
      fetchOne(24'h300040, 24'h400100, 0, 0, 0, 1, 0, 16'h0100, 20'h00000, 24'h300041);

      // Reset in the middle of an outstanding fetch with an ack arriving.
      @(negedge Clock);
      IMemAck  = 1'b1;
      IMemData = 24'h777777;
      Reset    = 1'b1;
      #1;
      checkEq("midRstReq", 32'(IMemReq), 32'd0);
      checkEq("midRstPc", 32'(PC), 32'h100);
      checkEq("midRstValid", 32'(InstrValid), 32'd0);
      checkEq("midRstInstr", 32'(Instr), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock); #1;
      checkEq("ackInIdleIgnored", 32'(InstrValid), 32'd0);
      checkEq("restartReq", 32'(IMemReq), 32'd1);
      IMemAck = 1'b0;
      fetchOne(24'h000100, 24'h3000AA, 0, 0, 0, 0, 0, 16'h0000, 20'h00000, 24'h000101);

`ifdef IFU_FETCH_TIMEOUT_EN
      repeat (15) @(posedge Clock);
      #1;
      checkEq("wdStillFetch", 32'(IMemReq), 32'd1);
      checkEq("wdNoErrYet", 32'(FetchErr), 32'd0);
      checkEq("wdNotValid", 32'(InstrValid), 32'd0);
      @(posedge Clock); #1;
      checkEq("wdErr", 32'(FetchErr), 32'd1);
      checkEq("wdNopInstr", 32'(Instr), 32'd0);
      checkEq("wdValid", 32'(InstrValid), 32'd1);
      checkEq("wdPc", 32'(PC), 32'h101);
      checkEq("wdReqLow", 32'(IMemReq), 32'd0);
      @(posedge Clock); #1;
      checkEq("wdNextAddr", 32'(IMemAddr), 32'h102);
      checkEq("wdSticky", 32'(FetchErr), 32'd1);
`else
      repeat (30) @(posedge Clock);
      #1;
      checkEq("waitReqHeld", 32'(IMemReq), 32'd1);
      checkEq("waitNoValid", 32'(InstrValid), 32'd0);
      checkEq("waitAddr", 32'(IMemAddr), 32'h101);
      checkEq("waitNoErr", 32'(FetchErr), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
